simple_wb_buffer: RTL and testbench
===================================

Name: simple_wb_buffer

Overview:
- Receive end of the simple-ALU writeback interface: accepts one writeback packet per cycle from a simple execute lane and queues it in a DEPTH-entry FIFO.
- Drains the head entry to the shared physical register file write port, the bypass network and the active-list completion port.
- Decouples the lane from RF write-port arbitration and tracks the TOGGLE_S mode state.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- SIZE_DATA, 32, result data width.
- SIZE_PHYSICAL_LOG, 7, physical register tag width.
- SIZE_ACTIVELIST_LOG, 7, active-list ID width.
- SIZE_FLAGS, 4, flag bits: [3] destValid, [2] executed, [1] exception, [0] mispredict.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous squash of all queued entries.
- wbValid_i  in  1  incoming packet valid.
- wbReady_o  out  1  buffer can accept this cycle.
- wbLogDest_i  in  5  logical destination.
- wbPhyDest_i  in  SIZE_PHYSICAL_LOG  physical destination.
- wbData_i  in  SIZE_DATA  result data.
- wbAlID_i  in  SIZE_ACTIVELIST_LOG  active-list ID.
- wbFlags_i  in  SIZE_FLAGS  execution flags.
- toggleFlag_i  in  1  packet came from TOGGLE_S.
- rfGrant_i  in  1  RF write port granted to this buffer this cycle.
- rfWrEn_o  out  1  RF write enable.
- rfWrAddr_o  out  SIZE_PHYSICAL_LOG  RF write tag.
- rfWrData_o  out  SIZE_DATA  RF write data.
- bypassValid_o  out  1  bypass broadcast valid.
- bypassTag_o  out  SIZE_PHYSICAL_LOG  bypass tag.
- bypassData_o  out  SIZE_DATA  bypass data.
- ctrlValid_o  out  1  active-list completion strobe.
- ctrlAlID_o  out  SIZE_ACTIVELIST_LOG  completing active-list ID.
- ctrlFlags_o  out  SIZE_FLAGS  completing flags.
- toggleState_o  out  1  current toggle mode.
- occupancy_o  out  log2(DEPTH)+1  entries held.
- overflowErr_o  out  1  sticky: packet presented while not ready.

Behaviour:
- Reset (synchronous, active-high, priority over everything): head and tail pointers 0, count 0, toggleState_o 0, overflowErr_o 0. All combinational outputs then read 0, except wbReady_o = 1.
- Enqueue:
  - Occurs when wbValid_i && wbReady_o && !flush_i.
  - Entry = {logDest, phyDest, data, alID, flags, toggle}; written at tail, tail wraps modulo DEPTH.
  - wbReady_o = (count < DEPTH); it does not depend on same-cycle pop, so a full buffer never accepts.
- Enqueue latency: 1 cycle. A packet accepted in cycle N is earliest visible at head in cycle N+1; there is no flow-through when empty.
- Head requests (combinational from the head entry; all 0 when empty):
  - needRf = headFlags[3].
  - pop = !empty && (rfGrant_i || !needRf).
- Drain outputs:
  - rfWrEn_o = pop && needRf; rfWrAddr_o and rfWrData_o are head phyDest and data.
  - bypassValid_o = rfWrEn_o; tag and data are the same as the RF write.
  - ctrlValid_o = pop; ctrlAlID_o and ctrlFlags_o are head alID and flags. This is a single-cycle strobe with no backpressure.
  - When not popping, all data outputs drive 0.
- rfGrant_i with an empty buffer, or with a non-writing head, is ignored.
- Simultaneous enqueue and pop: count unchanged, both pointers advance. This includes count == 1 (head pops while the new entry lands behind it).
- toggleState_o inverts on the clock edge of any pop whose head toggle bit is 1.
- Flush:
  - Clears count and resets both pointers to 0.
  - Suppresses same-cycle enqueue, and forces pop, rfWrEn_o and ctrlValid_o to 0 that cycle.
  - Does not change toggleState_o or overflowErr_o.
- Overflow:
  - wbValid_i && !wbReady_o && !flush_i sets overflowErr_o; it stays set until reset.
  - The offending packet is dropped and queued contents are unaffected.
- Flags are carried unmodified. Exception and mispredict do not alter buffer behaviour.
- occupancy_o equals count (registered).

Test Plan:
- Reset then idle: after reset, wbReady_o=1, occupancy_o=0, rfWrEn_o=0, ctrlValid_o=0, toggleState_o=0.
- Single write: enqueue phyDest=0x21, data=0xDEADBEEF, alID=5, flags=0xC with rfGrant_i held 1.
  - Cycle+1: rfWrEn_o=1, rfWrAddr_o=0x21, rfWrData_o=0xDEADBEEF, bypass identical, ctrlValid_o=1, ctrlAlID_o=5.
  - Cycle+2: occupancy_o=0.
- Backpressure to full: rfGrant_i=0 and 5 back-to-back packets (alID 1..5).
  - After 4 accepts, wbReady_o=0 and the 5th is dropped with overflowErr_o=1.
  - Raise rfGrant_i: ctrlAlID_o sequence is 1,2,3,4 on consecutive cycles, then occupancy_o=0.
- NOP drain without grant: enqueue flags=0x4 (destValid=0) with rfGrant_i=0.
  - Next cycle: ctrlValid_o=1, rfWrEn_o=0, bypassValid_o=0.
- Toggle: two TOGGLE_S packets (flags=0xC, toggleFlag_i=1, phyDest=0, data=0) with grant.
  - toggleState_o goes 0->1 after the first pop and 1->0 after the second; RF write to tag 0 with data 0 each time.
- Flush and wrap: fill 3 entries, assert flush_i together with a valid packet.
  - Next cycle: occupancy_o=0, no ctrlValid_o.
  - Then stream 10 packets with grant always 1: every alID completes in order exactly once across pointer wrap.

Source files
------------

// File: rtl/simple_wb_buffer.sv
// Writeback receive buffer for a simple ALU lane: queues packets in a small FIFO and drains
// the head to the RF write port, the bypass network and the active-list completion port.
module simple_wb_buffer #(
  parameter int unsigned DEPTH               = 4,
  parameter int unsigned SIZE_DATA           = 32,
  parameter int unsigned SIZE_PHYSICAL_LOG   = 7,
  parameter int unsigned SIZE_ACTIVELIST_LOG = 7,
  parameter int unsigned SIZE_FLAGS          = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush_i,

  input  logic                           wbValid_i,
  output logic                           wbReady_o,
  input  logic [4:0]                     wbLogDest_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0]   wbPhyDest_i,
  input  logic [SIZE_DATA-1:0]           wbData_i,
  input  logic [SIZE_ACTIVELIST_LOG-1:0] wbAlID_i,
  input  logic [SIZE_FLAGS-1:0]          wbFlags_i,
  input  logic                           toggleFlag_i,

  input  logic                           rfGrant_i,
  output logic                           rfWrEn_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]   rfWrAddr_o,
  output logic [SIZE_DATA-1:0]           rfWrData_o,

  output logic                           bypassValid_o,
  output logic [SIZE_PHYSICAL_LOG-1:0]   bypassTag_o,
  output logic [SIZE_DATA-1:0]           bypassData_o,

  output logic                           ctrlValid_o,
  output logic [SIZE_ACTIVELIST_LOG-1:0] ctrlAlID_o,
  output logic [SIZE_FLAGS-1:0]          ctrlFlags_o,

  output logic                           toggleState_o,
  output logic [$clog2(DEPTH):0]         occupancy_o,
  output logic                           overflowErr_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned DestValidBit = 3;

  typedef struct packed {
    logic [4:0]                     log_dest;
    logic [SIZE_PHYSICAL_LOG-1:0]   phy_dest;
    logic [SIZE_DATA-1:0]           data;
    logic [SIZE_ACTIVELIST_LOG-1:0] al_id;
    logic [SIZE_FLAGS-1:0]          flags;
    logic                           toggle;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            toggle_q, toggle_d;
  logic            overflow_q, overflow_d;

  entry_t head_entry;
  entry_t new_entry;
  logic   empty;
  logic   need_rf;
  logic   push;
  logic   pop;

  // Head decode and handshake.
  always_comb begin
    head_entry = mem_q[head_q];
    empty      = (count_q == '0);
    wbReady_o  = (count_q < CntW'(DEPTH));
    need_rf    = !empty && head_entry.flags[DestValidBit];
    push       = wbValid_i && wbReady_o && !flush_i;
    // Grant only matters when the head actually writes the RF.
    pop        = !empty && !flush_i && (rfGrant_i || !need_rf);

    new_entry.log_dest = wbLogDest_i;
    new_entry.phy_dest = wbPhyDest_i;
    new_entry.data     = wbData_i;
    new_entry.al_id    = wbAlID_i;
    new_entry.flags    = wbFlags_i;
    new_entry.toggle   = toggleFlag_i;
  end

  // Next-state for storage, pointers, count and status bits.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    toggle_d   = toggle_q;
    overflow_d = overflow_q;

    if (push) begin
      mem_d[tail_q] = new_entry;
    end

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PtrW'(1);
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
        count_d = count_q - CntW'(1);
      end
      if (wbValid_i && !wbReady_o) begin
        overflow_d = 1'b1;
      end
    end

    if (pop && head_entry.toggle) begin
      toggle_d = ~toggle_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      toggle_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      toggle_q   <= toggle_d;
      overflow_q <= overflow_d;
    end
  end

  // Drain outputs are zero whenever the head is not leaving this cycle.
  always_comb begin
    rfWrEn_o      = pop && need_rf;
    rfWrAddr_o    = pop ? head_entry.phy_dest : '0;
    rfWrData_o    = pop ? head_entry.data : '0;
    bypassValid_o = rfWrEn_o;
    bypassTag_o   = rfWrAddr_o;
    bypassData_o  = rfWrData_o;
    ctrlValid_o   = pop;
    ctrlAlID_o    = pop ? head_entry.al_id : '0;
    ctrlFlags_o   = pop ? head_entry.flags : '0;
    toggleState_o = toggle_q;
    occupancy_o   = count_q;
    overflowErr_o = overflow_q;
  end

endmodule

// File: tb/tb_simple_wb_buffer.sv
// Self-checking bench for simple_wb_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_simple_wb_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic        wbValid_i;
  logic        wbReady_o;
  logic [4:0]  wbLogDest_i;
  logic [6:0]  wbPhyDest_i;
  logic [31:0] wbData_i;
  logic [6:0]  wbAlID_i;
  logic [3:0]  wbFlags_i;
  logic        toggleFlag_i;
  logic        rfGrant_i;
  logic        rfWrEn_o;
  logic [6:0]  rfWrAddr_o;
  logic [31:0] rfWrData_o;
  logic        bypassValid_o;
  logic [6:0]  bypassTag_o;
  logic [31:0] bypassData_o;
  logic        ctrlValid_o;
  logic [6:0]  ctrlAlID_o;
  logic [3:0]  ctrlFlags_o;
  logic        toggleState_o;
  logic [2:0]  occupancy_o;
  logic        overflowErr_o;

  simple_wb_buffer #(
    .DEPTH              (DEPTH),
    .SIZE_DATA          (32),
    .SIZE_PHYSICAL_LOG  (7),
    .SIZE_ACTIVELIST_LOG(7),
    .SIZE_FLAGS         (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_i),
    .wbValid_i    (wbValid_i),
    .wbReady_o    (wbReady_o),
    .wbLogDest_i  (wbLogDest_i),
    .wbPhyDest_i  (wbPhyDest_i),
    .wbData_i     (wbData_i),
    .wbAlID_i     (wbAlID_i),
    .wbFlags_i    (wbFlags_i),
    .toggleFlag_i (toggleFlag_i),
    .rfGrant_i    (rfGrant_i),
    .rfWrEn_o     (rfWrEn_o),
    .rfWrAddr_o   (rfWrAddr_o),
    .rfWrData_o   (rfWrData_o),
    .bypassValid_o(bypassValid_o),
    .bypassTag_o  (bypassTag_o),
    .bypassData_o (bypassData_o),
    .ctrlValid_o  (ctrlValid_o),
    .ctrlAlID_o   (ctrlAlID_o),
    .ctrlFlags_o  (ctrlFlags_o),
    .toggleState_o(toggleState_o),
    .occupancy_o  (occupancy_o),
    .overflowErr_o(overflowErr_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  phy;
    logic [31:0] data;
    logic [6:0]  al;
    logic [3:0]  flags;
    logic        tog;
  } pkt_t;

  int         n_checks = 0;
  int         n_err = 0;
  pkt_t       mq[$];
  logic [6:0] done_q[$];
  logic       m_tog = 1'b0;
  logic       m_ovf = 1'b0;
  bit         model_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of packets, checked on the falling edge while inputs are
  // stable, then advanced to reflect what the coming rising edge must do.
  always @(negedge clk) begin
    pkt_t hd;
    bit   e_empty, e_ready, e_need, e_pop, e_rf;
    if (reset) begin
      mq.delete();
      m_tog       = 1'b0;
      m_ovf       = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      e_empty = (mq.size() == 0);
      e_ready = (mq.size() < DEPTH);
      hd      = e_empty ? pkt_t'(0) : mq[0];
      e_need  = !e_empty && hd.flags[3];
      e_pop   = !e_empty && !flush_i && (rfGrant_i || !e_need);
      e_rf    = e_pop && e_need;

      chk("m_ready",     64'(wbReady_o),     64'(e_ready));
      chk("m_rfWrEn",    64'(rfWrEn_o),      64'(e_rf));
      chk("m_rfWrAddr",  64'(rfWrAddr_o),    e_pop ? 64'(hd.phy) : 64'd0);
      chk("m_rfWrData",  64'(rfWrData_o),    e_pop ? 64'(hd.data) : 64'd0);
      chk("m_bypValid",  64'(bypassValid_o), 64'(e_rf));
      chk("m_bypTag",    64'(bypassTag_o),   e_pop ? 64'(hd.phy) : 64'd0);
      chk("m_bypData",   64'(bypassData_o),  e_pop ? 64'(hd.data) : 64'd0);
      chk("m_ctrlValid", 64'(ctrlValid_o),   64'(e_pop));
      chk("m_ctrlAlID",  64'(ctrlAlID_o),    e_pop ? 64'(hd.al) : 64'd0);
      chk("m_ctrlFlags", 64'(ctrlFlags_o),   e_pop ? 64'(hd.flags) : 64'd0);
      chk("m_toggle",    64'(toggleState_o), 64'(m_tog));
      chk("m_occupancy", 64'(occupancy_o),   64'(mq.size()));
      chk("m_overflow",  64'(overflowErr_o), 64'(m_ovf));

      if (ctrlValid_o) done_q.push_back(ctrlAlID_o);

      if (flush_i) begin
        mq.delete();
      end else begin
        if (e_pop) begin
          if (hd.tog) m_tog = ~m_tog;
          void'(mq.pop_front());
        end
        if (wbValid_i && e_ready) begin
          mq.push_back({wbPhyDest_i, wbData_i, wbAlID_i, wbFlags_i, toggleFlag_i});
        end else if (wbValid_i) begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] phy, input logic [31:0] d,
                       input logic [6:0] al, input logic [3:0] fl, input logic tg);
    wbValid_i    = v;
    wbLogDest_i  = al[4:0];
    wbPhyDest_i  = phy;
    wbData_i     = d;
    wbAlID_i     = al;
    wbFlags_i    = fl;
    toggleFlag_i = tg;
  endtask

  initial begin
    reset     = 1'b1;
    flush_i   = 1'b0;
    rfGrant_i = 1'b0;
    drive(1'b0, 7'd0, 32'd0, 7'd0, 4'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Reset then idle.
    @(negedge clk);
    chk("rst_ready", 64'(wbReady_o), 64'd1);
    chk("rst_occ", 64'(occupancy_o), 64'd0);
    chk("rst_rfWrEn", 64'(rfWrEn_o), 64'd0);
    chk("rst_ctrlValid", 64'(ctrlValid_o), 64'd0);
    chk("rst_toggle", 64'(toggleState_o), 64'd0);

    // Single write, drains the cycle after acceptance.
    tick();
    rfGrant_i = 1'b1;
    drive(1'b1, 7'h21, 32'hDEADBEEF, 7'd5, 4'hC, 1'b0);
    tick();
    wbValid_i = 1'b0;
    @(negedge clk);
    chk("sw_rfWrEn", 64'(rfWrEn_o), 64'd1);
    chk("sw_rfWrAddr", 64'(rfWrAddr_o), 64'h21);
    chk("sw_rfWrData", 64'(rfWrData_o), 64'hDEADBEEF);
    chk("sw_bypValid", 64'(bypassValid_o), 64'd1);
    chk("sw_bypTag", 64'(bypassTag_o), 64'h21);
    chk("sw_bypData", 64'(bypassData_o), 64'hDEADBEEF);
    chk("sw_ctrlValid", 64'(ctrlValid_o), 64'd1);
    chk("sw_ctrlAlID", 64'(ctrlAlID_o), 64'd5);
    tick();
    @(negedge clk);
    chk("sw_occ_after", 64'(occupancy_o), 64'd0);

    // Backpressure to full, fifth packet dropped.
    tick();
    rfGrant_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 7'(8'h10 + i), 32'(i * 32'h111), 7'(i), 4'hC, 1'b0);
      tick();
    end
    wbValid_i = 1'b0;
    @(negedge clk);
    chk("bp_ready", 64'(wbReady_o), 64'd0);
    chk("bp_overflow", 64'(overflowErr_o), 64'd1);
    chk("bp_occ", 64'(occupancy_o), 64'd4);
    tick();
    rfGrant_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("bp_drain_valid", 64'(ctrlValid_o), 64'd1);
      chk("bp_drain_alid", 64'(ctrlAlID_o), 64'(i));
      tick();
    end
    @(negedge clk);
    chk("bp_occ_empty", 64'(occupancy_o), 64'd0);

    // NOP entry drains without a grant.
    tick();
    rfGrant_i = 1'b0;
    drive(1'b1, 7'h33, 32'h55, 7'd9, 4'h4, 1'b0);
    tick();
    wbValid_i = 1'b0;
    @(negedge clk);
    chk("nop_ctrlValid", 64'(ctrlValid_o), 64'd1);
    chk("nop_ctrlAlID", 64'(ctrlAlID_o), 64'd9);
    chk("nop_rfWrEn", 64'(rfWrEn_o), 64'd0);
    chk("nop_bypValid", 64'(bypassValid_o), 64'd0);

    // Two toggle packets back to back.
    tick();
    rfGrant_i = 1'b1;
    drive(1'b1, 7'h0, 32'h0, 7'd10, 4'hC, 1'b1);
    tick();
    drive(1'b1, 7'h0, 32'h0, 7'd11, 4'hC, 1'b1);
    @(negedge clk);
    chk("tg_state0", 64'(toggleState_o), 64'd0);
    chk("tg_rfWrEn0", 64'(rfWrEn_o), 64'd1);
    chk("tg_rfWrAddr0", 64'(rfWrAddr_o), 64'h0);
    tick();
    wbValid_i = 1'b0;
    @(negedge clk);
    chk("tg_state1", 64'(toggleState_o), 64'd1);
    chk("tg_rfWrEn1", 64'(rfWrEn_o), 64'd1);
    chk("tg_ctrlAlID1", 64'(ctrlAlID_o), 64'd11);
    tick();
    @(negedge clk);
    chk("tg_state2", 64'(toggleState_o), 64'd0);

    // Flush with a concurrent packet, then stream across the pointer wrap.
    tick();
    rfGrant_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 7'(8'h40 + i), 32'(i + 100), 7'(20 + i), 4'hC, 1'b0);
      tick();
    end
    flush_i = 1'b1;
    drive(1'b1, 7'h44, 32'd200, 7'd23, 4'hC, 1'b0);
    tick();
    flush_i   = 1'b0;
    wbValid_i = 1'b0;
    @(negedge clk);
    chk("fl_occ", 64'(occupancy_o), 64'd0);
    chk("fl_ctrlValid", 64'(ctrlValid_o), 64'd0);
    tick();
    rfGrant_i = 1'b1;
    done_q.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 7'(i), 32'(i * 3), 7'(30 + i), 4'hC, 1'(i));
      tick();
    end
    wbValid_i = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("st_count", 64'(done_q.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < done_q.size()) chk("st_order", 64'(done_q[i]), 64'(30 + i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished at %0t", $time);
    $fatal(1);
  end

endmodule
